// File: rtl/watch_pkg.sv
// Shared watch datapath constants and the packer state encoding.
// The binary-to-digit splitter uses the same width constants.
package watch_pkg;
    localparam int NUM_W   = 15;
    localparam int DIG_W   = 4;
    localparam int BCD_MAX = 9;

    typedef enum logic {
        IDLE,
        CONV
    } state_t;
endpackage

// File: rtl/bcd4_pack_if.sv
// Start/digit request and result bundle between a digit editor and the BCD packer.
interface bcd4_pack_if;
    import watch_pkg::*;

    logic             start;
    logic [DIG_W-1:0] a;
    logic [DIG_W-1:0] b;
    logic [DIG_W-1:0] c;
    logic [DIG_W-1:0] d;
    logic             busy;
    logic             done;
    logic [NUM_W-1:0] number;
    logic             err;

    modport master (
        output start, a, b, c, d,
        input  busy, done, number, err
    );

    modport slave (
        input  start, a, b, c, d,
        output busy, done, number, err
    );
endinterface

// File: rtl/bcd4_pack_mul10_add.sv
// One Horner step: acc*10 + dig at NUM_W width, flagging a non-BCD digit.
module mul10_add
    import watch_pkg::*;
(
    input  logic [NUM_W-1:0] i_acc,
    input  logic [DIG_W-1:0] i_dig,
    output logic [NUM_W-1:0] o_sum,
    output logic             o_dig_bad
);
    // Shift-and-add keeps the multiply out of a DSP; wrap on illegal digits is harmless.
    assign o_sum     = (i_acc << 3) + (i_acc << 1) + NUM_W'(i_dig);
    assign o_dig_bad = (i_dig > DIG_W'(BCD_MAX));
endmodule

// File: rtl/bcd4_pack.sv
// Sequential BCD-to-binary packer: latches four digits, folds them MSD first, one per cycle.
module bcd4_pack
    import watch_pkg::*;
#(
    parameter int NDIG = 4
)
(
    input  logic        clk,
    input  logic        rst_n,
    bcd4_pack_if.slave  bus
);
    localparam int IDX_W = $clog2(NDIG);

    state_t           r_state;
    logic [DIG_W-1:0] r_digit [NDIG];
    logic [NUM_W-1:0] r_acc;
    logic [IDX_W-1:0] r_idx;
    logic             r_bad;
    logic             r_busy;
    logic             r_done;
    logic [NUM_W-1:0] r_number;
    logic             r_err;

    wire [NUM_W-1:0]  w_sum;
    wire              w_dig_bad;
    wire              w_err;

    mul10_add u_mul10_add (
        .i_acc     (r_acc),
        .i_dig     (r_digit[r_idx]),
        .o_sum     (w_sum),
        .o_dig_bad (w_dig_bad)
    );

    assign w_err = r_bad | w_dig_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            for (int i = 0; i < NDIG; i++) begin
                r_digit[i] <= '0;
            end
            r_acc    <= '0;
            r_idx    <= '0;
            r_bad    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_number <= '0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_digit[0] <= bus.a;
                        r_digit[1] <= bus.b;
                        r_digit[2] <= bus.c;
                        r_digit[3] <= bus.d;
                        r_acc      <= '0;
                        r_idx      <= '0;
                        r_bad      <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= CONV;
                    end
                end
                CONV: begin
                    r_acc <= w_sum;
                    r_bad <= w_err;
                    r_idx <= r_idx + 1'b1;
                    // Last digit: publish result (zeroed on any bad digit) and free up for a new start.
                    if (r_idx == IDX_W'(NDIG - 1)) begin
                        r_number <= w_err ? '0 : w_sum;
                        r_err    <= w_err;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.number = r_number;
    assign bus.err    = r_err;
endmodule

// File: tb/tb_bcd4_pack.sv
// Randomized scoreboard bench for bcd4_pack: driver predicts from decimal arithmetic, monitor checks.
module tb_bcd4_pack;
    logic clk;
    logic rst_n;
    int   testsRun;
    int   testsFailed;
    int   cycleCnt;
    int   heldNum;
    int   heldErr;

    typedef struct {
        int num;
        int err;
        int doneCycle;
    } exp_t;

    exp_t expQ[$];

    bcd4_pack_if bus ();

    bcd4_pack dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleCnt);
        end
    endtask

    // Reference: plain decimal weighting; any non-BCD digit forces 0 with err.
    function automatic exp_t model(input int a, input int b, input int c, input int d, input int doneCycle);
        exp_t e;
        e.doneCycle = doneCycle;
        if (a > 9 || b > 9 || c > 9 || d > 9) begin
            e.num = 0;
            e.err = 1;
        end else begin
            e.num = a * 1000 + b * 100 + c * 10 + d;
            e.err = 0;
        end
        return e;
    endfunction

    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                                 input logic [3:0] c, input logic [3:0] d, input logic st);
        @(negedge clk);
        bus.a     = a;
        bus.b     = b;
        bus.c     = c;
        bus.d     = d;
        bus.start = st;
        if (st && !bus.busy && rst_n)
            expQ.push_back(model(int'(a), int'(b), int'(c), int'(d), cycleCnt + 5));
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
    endtask

    task automatic convert(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        applyStimulus(a, b, c, d, 1'b1);
        idleCycles(4);
    endtask

    function automatic logic [3:0] randDigit();
        if ($urandom_range(0, 7) == 0)
            return 4'($urandom_range(10, 15));
        return 4'($urandom_range(0, 9));
    endfunction

    // Monitor: samples just after each rising edge and retires expected results on done.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                checkOutput("reset_busy", int'(bus.busy), 0);
                checkOutput("reset_done", int'(bus.done), 0);
                checkOutput("reset_number", int'(bus.number), 0);
                checkOutput("reset_err", int'(bus.err), 0);
            end else begin
                if (bus.done) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_done", 1, 0);
                    end else begin
                        exp_t e;
                        e = expQ.pop_front();
                        checkOutput("done_cycle", cycleCnt, e.doneCycle);
                        heldNum = e.num;
                        heldErr = e.err;
                    end
                end else if (expQ.size() > 0 && cycleCnt >= expQ[0].doneCycle) begin
                    checkOutput("missing_done", 0, 1);
                    void'(expQ.pop_front());
                end
                checkOutput("busy", int'(bus.busy),
                            (expQ.size() > 0 && cycleCnt < expQ[0].doneCycle) ? 1 : 0);
                checkOutput("number", int'(bus.number), heldNum);
                checkOutput("err", int'(bus.err), heldErr);
            end
        end
    end

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        cycleCnt    = 0;
        heldNum     = 0;
        heldErr     = 0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.a       = '0;
        bus.b       = '0;
        bus.c       = '0;
        bus.d       = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        convert(4'd1, 4'd2, 4'd3, 4'd4);
        convert(4'd9, 4'd9, 4'd9, 4'd9);
        convert(4'd0, 4'd0, 4'd0, 4'd0);
        convert(4'd1, 4'hA, 4'd0, 4'd0);
        convert(4'd0, 4'd0, 4'd5, 4'd9);

        // Start held high with digits changing each cycle: new conversion every 5 cycles.
        for (int i = 0; i < 20; i++)
            applyStimulus(randDigit(), randDigit(), randDigit(), randDigit(), 1'b1);
        idleCycles(6);

        // Start re-pulsed and digits scrambled while busy must not disturb the latched value.
        applyStimulus(4'd7, 4'd3, 4'd0, 4'd8, 1'b1);
        for (int i = 0; i < 4; i++)
            applyStimulus(randDigit(), randDigit(), randDigit(), randDigit(), 1'b1);
        idleCycles(5);

        // Reset in the second conversion cycle aborts with no done.
        applyStimulus(4'd5, 4'd6, 4'd7, 4'd8, 1'b1);
        idleCycles(1);
        @(negedge clk);
        rst_n = 1'b0;
        expQ.delete();
        heldNum = 0;
        heldErr = 0;
        #1;
        checkOutput("abort_busy", int'(bus.busy), 0);
        checkOutput("abort_number", int'(bus.number), 0);
        checkOutput("abort_done", int'(bus.done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        convert(4'd0, 4'd4, 4'd2, 4'd0);

        for (int i = 0; i < 400; i++)
            applyStimulus(randDigit(), randDigit(), randDigit(), randDigit(),
                          ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);

        for (int i = 0; i < 20 && expQ.size() > 0; i++)
            applyStimulus(4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        checkOutput("drain_pending", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
